// File: rtl/i2c_pkg.sv
// Shared I2C definitions: address/data widths and the slave FSM state type.
package i2c_pkg;

   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK,
      WAIT_STOP
   } state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop input synchroniser with rise/fall strobes on the synchronised level.
module i2c_sync_edge #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sr;
   logic              prev;

   // Reset to 1 so an idle (pulled-up) bus produces no edge after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr   <= '1;
         prev <= 1'b1;
      end else begin
         sr   <= {sr[STAGES-2:0], din};
         prev <= sr[STAGES-1];
      end
   end

   assign dout = sr[STAGES-1];
   assign rise = dout & ~prev;
   assign fall = ~dout & prev;

endmodule

// File: rtl/i2c_mem_slave.sv
// I2C slave backed by a 7-bit addressed byte memory: single-byte write or read
// per transaction, every address byte acknowledged.
module i2c_mem_slave #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned MEM_DEPTH   = 128
) (
   input  logic clk,
   input  logic rst,
   input  logic scl,
   inout  logic sda,
   output logic busy,
   output logic wrStrobe,
   output logic rdStrobe
);

   import i2c_pkg::*;

   logic scl_s, scl_rise, scl_fall;
   logic sda_s, sda_rise, sda_fall;

   i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (scl),
      .dout (scl_s),
      .rise (scl_rise),
      .fall (scl_fall)
   );

   i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (sda),
      .dout (sda_s),
      .rise (sda_rise),
      .fall (sda_fall)
   );

   state_t              state, next_state;
   logic [2:0]          bit_cnt;
   logic [DATA_W-1:0]   shift;
   logic [ADDR_W-1:0]   addr;
   logic                rw;
   logic                sda_low;
   logic                wr_pulse, rd_pulse;
   logic [DATA_W-1:0]   mem [MEM_DEPTH];

   logic start, stop, byte_done, ack_done, commit;

   assign start     = sda_fall & scl_s;
   assign stop      = sda_rise & scl_s;
   assign byte_done = scl_rise & (bit_cnt == 3'd7);
   // ACK states use bit_cnt as a phase: 0 = waiting to pull low, 1 = holding low.
   assign ack_done  = scl_fall & (bit_cnt == 3'd1);
   assign commit    = (state == WR_ACK) & ack_done & ~start & ~stop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (stop) begin
         next_state = IDLE;
      end else if (start) begin
         next_state = ADDR;
      end else begin
         unique case (state)
            IDLE:      next_state = IDLE;
            ADDR:      if (byte_done) next_state = ADDR_ACK;
            ADDR_ACK:  if (ack_done)  next_state = rw ? RD_DATA : WR_DATA;
            WR_DATA:   if (byte_done) next_state = WR_ACK;
            WR_ACK:    if (ack_done)  next_state = WAIT_STOP;
            RD_DATA:   if (byte_done) next_state = RD_ACK;
            RD_ACK:    if (scl_rise)  next_state = WAIT_STOP;
            WAIT_STOP: next_state = WAIT_STOP;
            default:   next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      busy     = (state != IDLE);
      wrStrobe = wr_pulse;
      rdStrobe = rd_pulse;
   end

   assign sda = sda_low ? 1'b0 : 1'bz;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift    <= '0;
         bit_cnt  <= '0;
         addr     <= '0;
         rw       <= 1'b0;
         sda_low  <= 1'b0;
         wr_pulse <= 1'b0;
         rd_pulse <= 1'b0;
      end else begin
         wr_pulse <= 1'b0;
         rd_pulse <= 1'b0;
         if (stop || start) begin
            sda_low <= 1'b0;
            bit_cnt <= '0;
         end else begin
            unique case (state)
               ADDR, WR_DATA: begin
                  if (scl_rise) begin
                     shift <= {shift[DATA_W-2:0], sda_s};
                     if (bit_cnt == 3'd7) begin
                        bit_cnt <= '0;
                        if (state == ADDR) begin
                           addr <= shift[ADDR_W-1:0];
                           rw   <= sda_s;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                     end
                  end
               end
               ADDR_ACK, WR_ACK: begin
                  if (scl_fall) begin
                     if (bit_cnt == 3'd0) begin
                        sda_low <= 1'b1;
                        bit_cnt <= 3'd1;
                     end else begin
                        sda_low <= 1'b0;
                        bit_cnt <= '0;
                        if (state == WR_ACK) begin
                           wr_pulse <= 1'b1;
                        end else if (rw) begin
                           // MSB goes out on the same fall that ends the address ACK.
                           shift    <= mem[addr];
                           sda_low  <= ~mem[addr][DATA_W-1];
                           rd_pulse <= 1'b1;
                        end
                     end
                  end
               end
               RD_DATA: begin
                  if (scl_rise) begin
                     bit_cnt <= (bit_cnt == 3'd7) ? 3'd0 : bit_cnt + 3'd1;
                  end else if (scl_fall) begin
                     shift   <= {shift[DATA_W-2:0], 1'b0};
                     sda_low <= ~shift[DATA_W-2];
                  end
               end
               RD_ACK: begin
                  if (scl_fall) sda_low <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (commit) mem[addr] <= shift;
   end

endmodule

// File: doc/i2c_mem_slave.md
I2C_MEM_SLAVE -- requirements
Module: i2c_mem_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flops in the scl and sda input synchronisers (minimum 2).
REQ-002 Parameter MEM_DEPTH, default 128: number of bytes in the memory, indexed by the 7-bit address field.
REQ-003 clk  input  1  system clock, the same clock that drives the master.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 scl  input  1  I2C clock from the master.
REQ-006 sda  inout  1  I2C data, open-drain: the block drives only 0 or Z.
REQ-007 busy  output  1  high from START detection until STOP detection or return to IDLE.
REQ-008 wrStrobe  output  1  one-clk pulse when a write byte commits to memory.
REQ-009 rdStrobe  output  1  one-clk pulse when a read byte is loaded into the transmit shift register.

Function
REQ-010 scl and sda shall pass through SYNC_STAGES flops, with rise/fall detection on the synchronised values.
REQ-011 START shall be detected as synced sda falling while synced scl is high; STOP as synced sda rising while synced scl is high.
REQ-012 The FSM states shall be IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK and WAIT_STOP.
REQ-013 IDLE->ADDR on START; START in any state (repeated start) -> ADDR, clearing the bit counter.
REQ-014 STOP in any state -> IDLE, releasing sda within 1 clk.
REQ-015 ADDR: sample 8 bits MSB-first on scl rise; bits[7:1] give the memory address, bit[0] gives rw (1 = read).
REQ-016 ADDR_ACK: drive sda=0 from the scl fall after bit 8 until the following scl fall. Every transaction is acknowledged; there is no device-address match.
REQ-017 After ADDR_ACK: rw=0 -> WR_DATA; rw=1 -> RD_DATA, loading mem[addr] into the shift register and pulsing rdStrobe.
REQ-018 WR_DATA: shift 8 bits on scl rise.
REQ-019 WR_ACK: drive sda=0 for the ninth bit; write mem[addr]<=byte and pulse wrStrobe on the scl fall ending the ACK; then -> WAIT_STOP.
REQ-020 RD_DATA: drive each bit (0 -> sda=0, 1 -> Z) starting 1 clk after each scl fall. The MSB is driven from the scl fall ending ADDR_ACK.
REQ-021 RD_ACK: release sda and sample the master ACK on scl rise. ACK or NACK -> WAIT_STOP; there is no multi-byte read.
REQ-022 WAIT_STOP: sda released, ignore scl edges, wait for STOP or START.
REQ-023 sda shall never change while synced scl is high, except through a STOP/START-driven release.
REQ-024 The bit counter shall be 3 bits and wrap 7->0 only on a state change.
REQ-025 Address arithmetic shall be 7-bit with no increment.

Reset
REQ-026 Asserting rst shall, asynchronously: put the FSM in IDLE, release sda (Z), drive busy=0, wrStrobe=0, rdStrobe=0, and clear the shift register, bit counter and synchronisers (synchronisers to 1).
REQ-027 Memory contents shall be unaffected by rst.
REQ-028 rst mid-transaction shall abort with no memory write, and the next valid START shall be decoded normally.

Structure
REQ-029 Package i2c_pkg shall hold the state enum typedef, ADDR_W=7 and DATA_W=8, shared with master.
REQ-030 Sub-module i2c_sync_edge (synchroniser plus rise/fall outputs) shall be instantiated once for scl and once for sda.
REQ-031 Memory shall be a plain register array written only in WR_ACK.

Verification
REQ-032 Master write addr=7'h12, din=8'hA5, then read addr=7'h12 -> dout=8'hA5, ackErr=0, one wrStrobe and one rdStrobe pulse.
REQ-033 Write 7'h00=8'h01 and 7'h7F=8'hFE, then read both back -> 8'h01 and 8'hFE respectively (address boundaries).
REQ-034 Force STOP after 4 data bits of a write to 7'h30 -> no wrStrobe, mem[0x30] unchanged, busy falls within SYNC_STAGES+2 clk.
REQ-035 Repeated START during WR_DATA, then a read of 7'h12 -> FSM re-enters ADDR and returns the prior value 8'hA5.
REQ-036 Assert rst during RD_DATA -> sda=Z within the same clk edge, busy=0; a following write/read of 7'h05=8'h3C passes.
REQ-037 Assertion on every scl-high interval in all tests: no sda transition except START/STOP.
